// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared constants, FSM state type and address helpers for the 5x5 Conv2D
// window scheduler. Geometry: 32x32 image, 5x5 kernel, 28x28 output map,
// 6 kernels. Output maps are stored back to back (784 words per kernel).
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int IMG_W        = 32;
    localparam int K            = 5;
    localparam int OUT_W        = IMG_W - K + 1;          // 28
    localparam int NUM_KERNELS  = 6;
    localparam int OUT_PIX      = OUT_W * OUT_W;          // 784
    localparam int ADDR_W       = 10;
    localparam int OUT_ADDR_W   = 13;
    localparam int MAX_INFLIGHT = 4;
    localparam int DATA_W       = 32;

    localparam int CNT_W        = $clog2(OUT_W);          // row/col counter width
    localparam int KERN_W       = 3;
    localparam int CREDIT_W     = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } sched_state_t;

    // Top-left pixel of the window at output position (row, col).
    function automatic logic [ADDR_W-1:0] win_addr(
        input logic [CNT_W-1:0] row,
        input logic [CNT_W-1:0] col
    );
        return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    endfunction

    // Feature-map address of output pixel (row, col) of kernel kern.
    function automatic logic [OUT_ADDR_W-1:0] out_addr(
        input logic [KERN_W-1:0] kern,
        input logic [CNT_W-1:0]  row,
        input logic [CNT_W-1:0]  col
    );
        return OUT_ADDR_W'(kern) * OUT_ADDR_W'(OUT_PIX)
             + OUT_ADDR_W'(row)  * OUT_ADDR_W'(OUT_W)
             + OUT_ADDR_W'(col);
    endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// -----------------------------------------------------------------------------
// conv_result_fifo
// Small synchronous FIFO holding Conv2D results until the output memory
// accepts them. A push into a full FIFO is accepted when a pop happens in the
// same cycle (the pop frees the slot).
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   push, din     write request and data (dropped only if full without pop)
//   pop           read request (ignored when empty)
//   dout          current head entry
//   empty, full   occupancy flags
//   count         number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module conv_result_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // NOTE: the storage array is deliberately not reset; only pointers and
    // count are. Stale words are never visible because empty gates the head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// -----------------------------------------------------------------------------
// conv_window_scheduler
// Walks every 5x5 window of a 32x32 image for each of 6 kernels, issuing one
// window per cycle to the Conv2D datapath while credits allow, buffers the
// in-order results and writes them to the feature map at
// kernel*784 + row*28 + col under out_ready backpressure.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start                    run request pulse (only honoured in IDLE)
//   busy, done_pulse         run status; done_pulse marks the last write done
//   win_base, kernel_idx     window address/kernel, valid with conv_enable
//   conv_enable              window issue strobe
//   conv_done, conv_result   Conv2D result return (in issue order)
//   out_ready                output memory can accept a write
//   out_wr_en/addr/data      output memory write port
// -----------------------------------------------------------------------------
module conv_window_scheduler
    import conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done_pulse,
    output logic [ADDR_W-1:0]     win_base,
    output logic [KERN_W-1:0]     kernel_idx,
    output logic                  conv_enable,
    input  logic                  conv_done,
    input  logic [DATA_W-1:0]     conv_result,
    input  logic                  out_ready,
    output logic                  out_wr_en,
    output logic [OUT_ADDR_W-1:0] out_wr_addr,
    output logic [DATA_W-1:0]     out_wr_data
);

    localparam logic [CNT_W-1:0]  LAST_POS  = CNT_W'(OUT_W - 1);
    localparam logic [KERN_W-1:0] LAST_KERN = KERN_W'(NUM_KERNELS - 1);

    sched_state_t        r_state;
    logic                r_busy;
    logic                r_done_pulse;
    logic                r_conv_enable;
    logic [ADDR_W-1:0]   r_win_base;
    logic [KERN_W-1:0]   r_kernel_idx;

    // Issue-side position
    logic [CNT_W-1:0]    r_col;
    logic [CNT_W-1:0]    r_row;
    logic [KERN_W-1:0]   r_kern;

    // Write-side position
    logic [CNT_W-1:0]    r_wcol;
    logic [CNT_W-1:0]    r_wrow;
    logic [KERN_W-1:0]   r_wkern;

    logic [CREDIT_W-1:0] r_inflight;

    logic [CREDIT_W:0]   w_credits_used;
    logic                w_issue;
    logic                w_last_issue;
    logic                w_done_ok;
    logic                w_wr_accept;
    logic [DATA_W-1:0]   w_fifo_dout;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [CREDIT_W-1:0] w_fifo_count;

    // A window holds a credit from issue until its result leaves the FIFO,
    // so inflight + buffered can never exceed the FIFO depth.
    assign w_credits_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_issue        = (r_state == ISSUE)
                         && (w_credits_used < (CREDIT_W + 1)'(MAX_INFLIGHT));
    assign w_last_issue   = (r_kern == LAST_KERN) && (r_row == LAST_POS)
                         && (r_col == LAST_POS);
    // A result with nothing outstanding is a protocol violation: drop it.
    assign w_done_ok      = conv_done && (r_inflight != '0);
    assign w_wr_accept    = !w_fifo_empty && out_ready;

    conv_result_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (DATA_W)
    ) u_result_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_done_ok),
        .pop   (w_wr_accept),
        .din   (conv_result),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    // Control FSM plus issue-side counters and registered issue outputs.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done_pulse  <= 1'b0;
            r_conv_enable <= 1'b0;
            r_win_base    <= '0;
            r_kernel_idx  <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_kern        <= '0;
        end else begin
            r_done_pulse  <= 1'b0;
            r_conv_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_kern  <= '0;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_conv_enable <= 1'b1;
                        r_win_base    <= win_addr(r_row, r_col);
                        r_kernel_idx  <= r_kern;
                        if (w_last_issue) begin
                            r_state <= DRAIN;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_kern  <= '0;
                        end else if (r_col == LAST_POS) begin
                            r_col <= '0;
                            if (r_row == LAST_POS) begin
                                r_row  <= '0;
                                r_kern <= r_kern + KERN_W'(1);
                            end else begin
                                r_row <= r_row + CNT_W'(1);
                            end
                        end else begin
                            r_col <= r_col + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if ((r_inflight == '0) && w_fifo_empty) begin
                        r_state      <= FINISH;
                        r_done_pulse <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Credit tracking and write-side position.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inflight <= '0;
            r_wcol     <= '0;
            r_wrow     <= '0;
            r_wkern    <= '0;
        end else begin
            case ({w_issue, w_done_ok})
                2'b10:   r_inflight <= r_inflight + CREDIT_W'(1);
                2'b01:   r_inflight <= r_inflight - CREDIT_W'(1);
                default: ;
            endcase

            if (w_wr_accept) begin
                if (r_wcol == LAST_POS) begin
                    r_wcol <= '0;
                    if (r_wrow == LAST_POS) begin
                        r_wrow  <= '0;
                        r_wkern <= (r_wkern == LAST_KERN) ? '0 : r_wkern + KERN_W'(1);
                    end else begin
                        r_wrow <= r_wrow + CNT_W'(1);
                    end
                end else begin
                    r_wcol <= r_wcol + CNT_W'(1);
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done_pulse  = r_done_pulse;
    assign conv_enable = r_conv_enable;
    assign win_base    = r_win_base;
    assign kernel_idx  = r_kernel_idx;
    assign out_wr_en   = !w_fifo_empty;
    assign out_wr_addr = out_addr(r_wkern, r_wrow, r_wcol);
    // FIFO storage is not reset, so mask the head while nothing is buffered.
    assign out_wr_data = w_fifo_empty ? '0 : w_fifo_dout;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_window_scheduler
// Scoreboard bench: expected issues and writes are generated from the image
// geometry when a run starts; a negedge monitor compares every issue and
// accepted write in order. A Conv2D model returns a keyed result a fixed
// number of cycles after each issue. A standalone FIFO instance exercises
// simultaneous push/pop while full.
// -----------------------------------------------------------------------------
module tb_conv_window_scheduler;
    import conv_pkg::*;

    localparam int TOTAL   = NUM_KERNELS * OUT_PIX;
    localparam int TIMEOUT = 40000;

    typedef struct {
        logic [KERN_W-1:0] kern;
        logic [ADDR_W-1:0] base;
    } iss_t;

    typedef struct {
        logic [OUT_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } pend_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  busy;
    logic                  done_pulse;
    logic [ADDR_W-1:0]     win_base;
    logic [KERN_W-1:0]     kernel_idx;
    logic                  conv_enable;
    logic                  conv_done = 1'b0;
    logic [DATA_W-1:0]     conv_result = '0;
    logic                  out_ready;
    logic                  out_wr_en;
    logic [OUT_ADDR_W-1:0] out_wr_addr;
    logic [DATA_W-1:0]     out_wr_data;

    logic                  f_push;
    logic                  f_pop;
    logic [DATA_W-1:0]     f_din;
    logic [DATA_W-1:0]     f_dout;
    logic                  f_empty;
    logic                  f_full;
    logic [CREDIT_W-1:0]   f_count;

    int errors = 0;
    int checks = 0;

    iss_t  exp_issue_q[$];
    wr_t   exp_wr_q[$];
    pend_t pend_q[$];

    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    logic [31:0] salt = '0;
    bit          run_active = 1'b0;
    bit          spurious = 1'b0;
    bit          prev_done = 1'b0;
    int          issues_seen = 0;
    int          writes_seen = 0;
    int          done_count = 0;
    int          busy_gaps = 0;
    int          max_out = 0;
    logic [ADDR_W-1:0] trace_base [800];
    logic [KERN_W-1:0] trace_kern [800];

    conv_window_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .win_base    (win_base),
        .kernel_idx  (kernel_idx),
        .conv_enable (conv_enable),
        .conv_done   (conv_done),
        .conv_result (conv_result),
        .out_ready   (out_ready),
        .out_wr_en   (out_wr_en),
        .out_wr_addr (out_wr_addr),
        .out_wr_data (out_wr_data)
    );

    conv_result_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (f_push),
        .pop   (f_pop),
        .din   (f_din),
        .dout  (f_dout),
        .empty (f_empty),
        .full  (f_full),
        .count (f_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Conv2D result for a window, keyed on kernel and window base.
    function automatic logic [31:0] conv_ref(input logic [KERN_W-1:0] k,
                                             input logic [ADDR_W-1:0] base,
                                             input logic [31:0] s);
        logic [31:0] key;
        key = {19'd0, k, base};
        return s ^ (key * 32'h9E3779B1) ^ {base, 22'd0};
    endfunction

    // Monitor + Conv2D model, both away from the active edge.
    always @(negedge clk) begin
        iss_t  ei;
        wr_t   ew;
        pend_t p;
        if (!rst) begin
            pend_q.delete();
            conv_done   = 1'b0;
            conv_result = '0;
            prev_done   = 1'b0;
            last_due    = 0;
        end else begin
            if (prev_done) check("done_to_wr_en_latency", out_wr_en, 1'b1);

            if (conv_enable) begin
                if (issues_seen < 800) begin
                    trace_base[issues_seen] = win_base;
                    trace_kern[issues_seen] = kernel_idx;
                end
                if (exp_issue_q.size() == 0) begin
                    fail_now("unexpected_issue");
                end else begin
                    ei = exp_issue_q.pop_front();
                    check("issue_win_base", win_base, ei.base);
                    check("issue_kernel_idx", kernel_idx, ei.kern);
                end
                issues_seen++;
            end

            if (out_wr_en && out_ready) begin
                if (exp_wr_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    ew = exp_wr_q.pop_front();
                    check("wr_addr", out_wr_addr, ew.addr);
                    check("wr_data", out_wr_data, ew.data);
                end
                writes_seen++;
            end

            if (issues_seen - writes_seen > max_out) max_out = issues_seen - writes_seen;

            if (done_pulse) begin
                done_count++;
                check("busy_low_with_done", busy, 1'b0);
            end else if (run_active && !busy) begin
                busy_gaps++;
            end

            conv_done   = 1'b0;
            conv_result = '0;
            prev_done   = 1'b0;
            if (spurious) begin
                conv_done   = 1'b1;
                conv_result = 32'hDEAD_BEEF;
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                conv_done   = 1'b1;
                conv_result = pend_q[0].data;
                void'(pend_q.pop_front());
                prev_done   = 1'b1;
            end
            if (conv_enable) begin
                p.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                p.data   = conv_ref(kernel_idx, win_base, salt);
                last_due = p.due;
                pend_q.push_back(p);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done_pulse"}, done_pulse, 1'b0);
        check({tag, "_conv_enable"}, conv_enable, 1'b0);
        check({tag, "_out_wr_en"}, out_wr_en, 1'b0);
        check({tag, "_win_base"}, win_base, '0);
        check({tag, "_kernel_idx"}, kernel_idx, '0);
        check({tag, "_out_wr_addr"}, out_wr_addr, '0);
        check({tag, "_out_wr_data"}, out_wr_data, '0);
    endtask

    task automatic start_run(input int latency);
        iss_t ei;
        wr_t  ew;
        lat  = latency;
        salt = $urandom;
        exp_issue_q.delete();
        exp_wr_q.delete();
        for (int k = 0; k < NUM_KERNELS; k++) begin
            for (int r = 0; r < OUT_W; r++) begin
                for (int c = 0; c < OUT_W; c++) begin
                    ei.kern = KERN_W'(k);
                    ei.base = ADDR_W'(r * IMG_W + c);
                    exp_issue_q.push_back(ei);
                    ew.addr = OUT_ADDR_W'(k * OUT_PIX + r * OUT_W + c);
                    ew.data = conv_ref(ei.kern, ei.base, salt);
                    exp_wr_q.push_back(ew);
                end
            end
        end
        issues_seen = 0;
        writes_seen = 0;
        done_count  = 0;
        busy_gaps   = 0;
        max_out     = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        run_active = 1'b1;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input string tag, input bit rand_ready,
                             input int stall_at, input int restart_at);
        int n = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit restarted = 1'b0;
        while (done_count == 0 && n < TIMEOUT) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                out_ready = 1'b0;
                if (stall_left == 1) begin
                    check({tag, "_stall_conv_enable"}, conv_enable, 1'b0);
                    check({tag, "_stall_wr_en"}, out_wr_en, 1'b1);
                end
            end else if (!stalled && stall_at >= 0 && writes_seen >= stall_at) begin
                stalled    = 1'b1;
                stall_left = 19;
                out_ready  = 1'b0;
            end else begin
                out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (!restarted && restart_at >= 0 && writes_seen >= restart_at) begin
                restarted = 1'b1;
                start     = 1'b1;
                check({tag, "_busy_at_restart"}, busy, 1'b1);
            end
            n++;
        end
        if (done_count == 0) fail_now({tag, "_timeout"});
        run_active = 1'b0;
        out_ready  = 1'b1;
        start      = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_writes"}, writes_seen, TOTAL);
        check({tag, "_issues"}, issues_seen, TOTAL);
        check({tag, "_wr_queue_left"}, exp_wr_q.size(), 0);
        check({tag, "_issue_queue_left"}, exp_issue_q.size(), 0);
        check({tag, "_done_pulses"}, done_count, 1);
        check({tag, "_busy_gaps"}, busy_gaps, 0);
        check({tag, "_max_outstanding_le4"}, (max_out <= MAX_INFLIGHT), 1'b1);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic fifo_test();
        logic [31:0] model_q[$];
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            @(posedge clk); #1;
            f_push = 1'b1;
            f_din  = 32'h100 + 32'(i);
            model_q.push_back(f_din);
        end
        @(posedge clk); #1;
        f_push = 1'b0;
        check("fifo_full_flag", f_full, 1'b1);
        check("fifo_count_full", f_count, 4);
        check("fifo_head_before_swap", f_dout, model_q[0]);
        f_push = 1'b1;
        f_pop  = 1'b1;
        f_din  = 32'hABCD_0123;
        void'(model_q.pop_front());
        model_q.push_back(f_din);
        @(posedge clk); #1;
        f_push = 1'b0;
        f_pop  = 1'b0;
        check("fifo_count_after_swap", f_count, 4);
        check("fifo_full_after_swap", f_full, 1'b1);
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            check("fifo_order", f_dout, model_q.pop_front());
            f_pop = 1'b1;
            @(posedge clk); #1;
            f_pop = 1'b0;
        end
        check("fifo_empty_after_drain", f_empty, 1'b1);
        check("fifo_count_after_drain", f_count, 0);
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        f_push    = 1'b0;
        f_pop     = 1'b0;
        f_din     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;

        // Run A: latency 3, no backpressure; also inspect boundary trace.
        start_run(3);
        wait_done("runA", 1'b0, -1, -1);
        check("trace_26_base", trace_base[26], 26);
        check("trace_27_base", trace_base[27], 27);
        check("trace_28_base", trace_base[28], 32);
        check("trace_29_base", trace_base[29], 33);
        check("trace_783_base", trace_base[783], 891);
        check("trace_783_kern", trace_kern[783], 0);
        check("trace_784_base", trace_base[784], 0);
        check("trace_784_kern", trace_kern[784], 1);

        // Run B: latency 1, 20-cycle stall, and a start while busy.
        start_run(1);
        wait_done("runB", 1'b0, 500, 2000);

        // Run C: reset at write 1000, then a full run with random ready.
        start_run(int'($urandom_range(4, 1)));
        n = 0;
        while (writes_seen < 1000 && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        if (writes_seen < 1000) fail_now("abort_timeout");
        rst = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b1;
        run_active = 1'b0;
        check_reset_outputs("midrun_rst");
        start_run(2);
        wait_done("runC", 1'b1, -1, -1);

        // Stray conv_done in IDLE must not create a write.
        @(posedge clk); #1;
        spurious = 1'b1;
        @(posedge clk); #1;
        spurious = 1'b0;
        check("spurious_done_wr_en", out_wr_en, 1'b0);
        @(posedge clk); #1;
        check("spurious_done_wr_en_later", out_wr_en, 1'b0);
        check("spurious_done_busy", busy, 1'b0);

        fifo_test();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
